// File: rtl/pc_fetch_pkg.sv
// Shared fetch-stage definitions: branch compare codes, FSM state encoding and the NOP word.
package pc_fetch_pkg;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StDrain
  } fetch_state_e;

  // Instruction fetches are word aligned; low address bits are ignored.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC logic: redirect target select with alignment, and sequential +4.
module pc_next
  import pc_fetch_pkg::*;
(
  input  logic        will_branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic [31:0] pc_i,
  output logic        redirect_o,
  output logic [31:0] target_o,
  output logic [31:0] pc_plus4_o
);

  assign redirect_o = will_branch_i | jump_i;
  // The EX-stage branch is older than the ID-stage jump, so it wins.
  assign target_o   = align_word(will_branch_i ? branch_target_i : jump_target_i);
  assign pc_plus4_o = pc_i + 32'd4;

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: one outstanding memory request, IF/ID register and redirect handling.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        will_branch,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        flush
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         if_valid_q, if_valid_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_instr_q, if_instr_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        req_fire;

  pc_next u_pc_next (
    .will_branch_i   (will_branch),
    .branch_target_i (branch_target),
    .jump_i          (jump),
    .jump_target_i   (jump_target),
    .pc_i            (pc_q),
    .redirect_o      (redirect),
    .target_o        (target),
    .pc_plus4_o      (pc_plus4)
  );

  // A new request only issues when the IF/ID slot is free or being consumed this cycle.
  assign imem_req_valid = rst_n && (state_q == StReq) && (!if_valid_q || !stall);
  assign imem_addr      = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign flush          = redirect;

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;

    if (!stall) begin
      if_valid_d = 1'b0;
    end

    unique case (state_q)
      StReq: begin
        if (req_fire) begin
          state_d = redirect ? StDrain : StWait;
        end
      end
      StWait: begin
        if (imem_rsp_valid) begin
          state_d = StReq;
          if (!redirect) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = imem_rsp_data;
            pc_d       = pc_plus4;
          end
        end else if (redirect) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (imem_rsp_valid) begin
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase

    if (redirect) begin
      pc_d       = target;
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StReq;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0000_0000;
      if_instr_q <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

endmodule
